// File: rtl/mem_resp_pkg.sv
// Shared types and default sizing for the MAR/MDR memory responder.
package mem_resp_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 9;
  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_DEPTH       = 512;
  localparam int unsigned DEF_WAIT_STATES = 2;
  localparam int unsigned CNT_WIDTH       = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Index width needed to address every implemented word.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit (MAR/MDR side) and the memory responder.
interface mem_responder_if
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] Mem_in;
  logic                  MDR_read;
  logic                  RAM_write;
  logic [DATA_WIDTH-1:0] Mem_out;
  logic                  Mem_done;
  logic                  Mem_busy;
  logic                  Mem_err;

  modport master (
    output Address, Mem_in, MDR_read, RAM_write,
    input  Mem_out, Mem_done, Mem_busy, Mem_err
  );

  modport slave (
    input  Address, Mem_in, MDR_read, RAM_write,
    output Mem_out, Mem_done, Mem_busy, Mem_err
  );

endinterface

// File: rtl/mem_responder_array.sv
// Single-port word RAM with a registered read port that holds its last value.
module mem_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned IDX_W      = idx_width(DEF_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents survive reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (we_i && !rst_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one level request, waits WAIT_STATES cycles,
// performs the access, pulses Mem_done, then waits for the request to drop.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input logic            Clock,
  input logic            Reset,
  mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(DEPTH);

  state_e                 state_q;
  op_e                    op_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   done_q;
  logic                   busy_q;
  logic                   err_q;

  logic                   rd_c;
  logic                   wr_c;
  logic                   illegal_c;
  logic                   we_c;
  logic                   re_c;
  logic [DATA_WIDTH-1:0]  rdata_c;

  assign rd_c      = bus.MDR_read;
  assign wr_c      = bus.RAM_write;
  assign illegal_c = (rd_c && wr_c) || (32'(bus.Address) >= DEPTH);

  // Control FSM with wait counter; request inputs only matter in IDLE and RELEASE.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_RD;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rd_c || wr_c) begin
            busy_q <= 1'b1;
            if (illegal_c) begin
              err_q   <= 1'b1;
              state_q <= ST_RELEASE;
            end else begin
              op_q    <= wr_c ? OP_WR : OP_RD;
              addr_q  <= bus.Address;
              data_q  <= bus.Mem_in;
              cnt_q   <= CNT_WIDTH'(WAIT_STATES);
              state_q <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          done_q  <= 1'b1;
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Holding either request keeps us here so a level is never re-triggered.
          if (!rd_c && !wr_c) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign we_c = (state_q == ST_ACCESS) && (op_q == OP_WR);
  assign re_c = (state_q == ST_ACCESS) && (op_q == OP_RD);

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem_array (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .we_i    (we_c),
    .re_i    (re_c),
    .addr_i  (addr_q[IDX_W-1:0]),
    .wdata_i (data_q),
    .rdata_o (rdata_c)
  );

  assign bus.Mem_out  = rdata_c;
  assign bus.Mem_done = done_q;
  assign bus.Mem_busy = busy_q;
  assign bus.Mem_err  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (2 wait states, 0 wait states, 256-word depth)
// driven by directed and random requests, checked against a transaction-level model.
module tb_mem_responder;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) b2 ();
  mem_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) b0 ();
  mem_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bd ();

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(512), .WAIT_STATES(2)) u_w2 (
    .Clock(clk), .Reset(rst), .bus(b2));
  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(512), .WAIT_STATES(0)) u_w0 (
    .Clock(clk), .Reset(rst), .bus(b0));
  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(1)) u_d256 (
    .Clock(clk), .Reset(rst), .bus(bd));

  int n_cmp;
  int n_fail;

  // Reference model: per-instance RAM image and last read value.
  logic [31:0] mdl_ram [3][512];
  bit          mdl_vld [3][512];
  logic [31:0] mdl_out [3];

  function automatic int ws(input int sel);
    return (sel == 0) ? 2 : ((sel == 1) ? 0 : 1);
  endfunction

  function automatic int dp(input int sel);
    return (sel == 2) ? 256 : 512;
  endfunction

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] d);
    case (sel)
      0:       begin b2.MDR_read = rd; b2.RAM_write = wr; b2.Address = a; b2.Mem_in = d; end
      1:       begin b0.MDR_read = rd; b0.RAM_write = wr; b0.Address = a; b0.Mem_in = d; end
      default: begin bd.MDR_read = rd; bd.RAM_write = wr; bd.Address = a; bd.Mem_in = d; end
    endcase
  endtask

  task automatic sample(input int sel, output logic [31:0] o, output logic dn,
                        output logic bs, output logic er);
    case (sel)
      0:       begin o = b2.Mem_out; dn = b2.Mem_done; bs = b2.Mem_busy; er = b2.Mem_err; end
      1:       begin o = b0.Mem_out; dn = b0.Mem_done; bs = b0.Mem_busy; er = b0.Mem_err; end
      default: begin o = bd.Mem_out; dn = bd.Mem_done; bs = bd.Mem_busy; er = bd.Mem_err; end
    endcase
  endtask

  // Expected outcome of one request; cycle 1 is the cycle after the accepting edge.
  task automatic model_req(input int sel, input logic rd, input logic wr, input logic [8:0] a,
                           input logic [31:0] d, input int hold,
                           output int e_done, output int e_dcyc, output int e_err,
                           output int e_rel, output logic [31:0] e_out);
    int last;
    if ((rd && wr) || int'(a) >= dp(sel)) begin
      e_done = 0; e_dcyc = -1; e_err = 1; last = 1;
    end else begin
      e_done = 1; e_dcyc = ws(sel) + 2; e_err = 0; last = ws(sel) + 2;
      if (wr) begin
        mdl_ram[sel][a] = d;
        mdl_vld[sel][a] = 1'b1;
      end else begin
        mdl_out[sel] = mdl_ram[sel][a];
      end
    end
    e_rel = ((hold > last) ? hold : last) + 1;
    e_out = mdl_out[sel];
  endtask

  // Issue one request held for 'hold' edges and observe until Mem_busy falls.
  task automatic run_req(input int sel, input logic rd, input logic wr, input logic [8:0] a,
                         input logic [31:0] d, input int hold,
                         output int n_done, output int dcyc, output int n_err,
                         output int ecyc, output int rel, output logic [31:0] o_fin);
    logic [31:0] o;
    logic dn, bs, er;
    n_done = 0; dcyc = -1; n_err = 0; ecyc = -1; rel = -1; o_fin = 'x;
    drive(sel, rd, wr, a, d);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      sample(sel, o, dn, bs, er);
      if (dn) begin n_done++; dcyc = c; end
      if (er) begin n_err++; ecyc = c; end
      if (c == hold) drive(sel, 1'b0, 1'b0, a, d);
      if (!bs) begin rel = c; o_fin = o; break; end
    end
    drive(sel, 1'b0, 1'b0, a, d);
  endtask

  task automatic test_reset();
    logic [31:0] o;
    logic dn, bs, er;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      mdl_out[s] = '0;
      sample(s, o, dn, bs, er);
      n_cmp++;
      if (o !== 32'h0 || dn !== 1'b0 || bs !== 1'b0 || er !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: out=%h done=%b busy=%b err=%b, want all zero", s, o, dn, bs, er);
      end
    end
  endtask

  task automatic test_write_w2();
    int nd, dc, ne, ec, rl, ed, edc, ee, er;
    logic [31:0] of, eo;
    model_req(0, 1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 6, ed, edc, ee, er, eo);
    run_req(0, 1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 6, nd, dc, ne, ec, rl, of);
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL wr_done_cnt: got %0d want 1", nd); end
    n_cmp++; if (dc !== 4) begin n_fail++; $display("FAIL wr_done_cyc: got %0d want 4", dc); end
    n_cmp++; if (rl !== 7) begin n_fail++; $display("FAIL wr_release: got %0d want 7", rl); end
    n_cmp++; if (ne !== 0) begin n_fail++; $display("FAIL wr_err: got %0d want 0", ne); end
    model_req(0, 1'b1, 1'b0, 9'h010, 32'h0, 1, ed, edc, ee, er, eo);
    run_req(0, 1'b1, 1'b0, 9'h010, 32'h0, 1, nd, dc, ne, ec, rl, of);
    n_cmp++; if (of !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_readback: got %h want deadbeef", of); end
  endtask

  task automatic test_read_w0();
    int nd, dc, ne, ec, rl, ed, edc, ee, er;
    logic [31:0] of, eo;
    model_req(1, 1'b0, 1'b1, 9'h1FF, 32'h55, 1, ed, edc, ee, er, eo);
    run_req(1, 1'b0, 1'b1, 9'h1FF, 32'h55, 1, nd, dc, ne, ec, rl, of);
    n_cmp++; if (dc !== 2) begin n_fail++; $display("FAIL w0_wr_done_cyc: got %0d want 2", dc); end
    model_req(1, 1'b1, 1'b0, 9'h1FF, 32'h0, 1, ed, edc, ee, er, eo);
    run_req(1, 1'b1, 1'b0, 9'h1FF, 32'h0, 1, nd, dc, ne, ec, rl, of);
    n_cmp++; if (dc !== 2) begin n_fail++; $display("FAIL w0_rd_done_cyc: got %0d want 2", dc); end
    n_cmp++; if (rl !== 3) begin n_fail++; $display("FAIL w0_rd_release: got %0d want 3", rl); end
    n_cmp++; if (of !== 32'h55) begin n_fail++; $display("FAIL w0_rd_data: got %h want 00000055", of); end
  endtask

  task automatic test_held_read();
    int nd, dc, ne, ec, rl, ed, edc, ee, er;
    logic [31:0] of, eo;
    model_req(0, 1'b1, 1'b0, 9'h010, 32'h0, 10, ed, edc, ee, er, eo);
    run_req(0, 1'b1, 1'b0, 9'h010, 32'h0, 10, nd, dc, ne, ec, rl, of);
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL held_done_cnt: got %0d want 1", nd); end
    n_cmp++; if (rl !== 11) begin n_fail++; $display("FAIL held_release: got %0d want 11", rl); end
    model_req(0, 1'b1, 1'b0, 9'h010, 32'h0, 1, ed, edc, ee, er, eo);
    run_req(0, 1'b1, 1'b0, 9'h010, 32'h0, 1, nd, dc, ne, ec, rl, of);
    n_cmp++; if (nd !== 1 || dc !== 4) begin n_fail++; $display("FAIL held_rearm: got cnt=%0d cyc=%0d want 1/4", nd, dc); end
    n_cmp++; if (of !== 32'hDEADBEEF) begin n_fail++; $display("FAIL held_data: got %h want deadbeef", of); end
  endtask

  task automatic test_illegal();
    int nd, dc, ne, ec, rl, ed, edc, ee, er;
    logic [31:0] of, eo;
    model_req(0, 1'b1, 1'b1, 9'h010, 32'h0BAD0BAD, 2, ed, edc, ee, er, eo);
    run_req(0, 1'b1, 1'b1, 9'h010, 32'h0BAD0BAD, 2, nd, dc, ne, ec, rl, of);
    n_cmp++; if (ne !== 1 || ec !== 1) begin n_fail++; $display("FAIL both_err: got cnt=%0d cyc=%0d want 1/1", ne, ec); end
    n_cmp++; if (nd !== 0) begin n_fail++; $display("FAIL both_no_done: got %0d want 0", nd); end
    n_cmp++; if (rl !== 3) begin n_fail++; $display("FAIL both_release: got %0d want 3", rl); end
    model_req(0, 1'b1, 1'b0, 9'h010, 32'h0, 1, ed, edc, ee, er, eo);
    run_req(0, 1'b1, 1'b0, 9'h010, 32'h0, 1, nd, dc, ne, ec, rl, of);
    n_cmp++; if (of !== 32'hDEADBEEF) begin n_fail++; $display("FAIL both_ram_kept: got %h want deadbeef", of); end
    model_req(2, 1'b0, 1'b1, 9'h0FF, 32'hC0FFEE01, 1, ed, edc, ee, er, eo);
    run_req(2, 1'b0, 1'b1, 9'h0FF, 32'hC0FFEE01, 1, nd, dc, ne, ec, rl, of);
    model_req(2, 1'b1, 1'b0, 9'h0FF, 32'h0, 1, ed, edc, ee, er, eo);
    run_req(2, 1'b1, 1'b0, 9'h0FF, 32'h0, 1, nd, dc, ne, ec, rl, of);
    n_cmp++; if (nd !== 1 || of !== 32'hC0FFEE01) begin n_fail++; $display("FAIL d256_last_word: got done=%0d out=%h want 1/c0ffee01", nd, of); end
    for (int i = 0; i < 2; i++) begin
      logic [8:0] a;
      a = (i == 0) ? 9'h1FF : 9'h100;
      model_req(2, 1'b1, 1'b0, a, 32'h0, 1, ed, edc, ee, er, eo);
      run_req(2, 1'b1, 1'b0, a, 32'h0, 1, nd, dc, ne, ec, rl, of);
      n_cmp++;
      if (ne !== 1 || nd !== 0 || of !== 32'hC0FFEE01) begin
        n_fail++;
        $display("FAIL d256_oor[%h]: got err=%0d done=%0d out=%h want 1/0/c0ffee01", a, ne, nd, of);
      end
    end
  endtask

  task automatic test_reset_mid(input int at_c, input logic [31:0] prior, input logic [31:0] newv);
    int nd, dc, ne, ec, rl, ed, edc, ee, er, bad;
    logic [31:0] of, eo, o;
    logic dn, bs, erp;
    model_req(0, 1'b0, 1'b1, 9'h020, prior, 1, ed, edc, ee, er, eo);
    run_req(0, 1'b0, 1'b1, 9'h020, prior, 1, nd, dc, ne, ec, rl, of);
    bad = 0;
    drive(0, 1'b0, 1'b1, 9'h020, newv);
    for (int c = 1; c <= at_c; c++) begin
      @(negedge clk);
      sample(0, o, dn, bs, erp);
      if (dn || erp || !bs) bad++;
    end
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 9'h020, newv);
    repeat (2) begin
      @(negedge clk);
      sample(0, o, dn, bs, erp);
      if (dn || erp || bs || o !== 32'h0) bad++;
    end
    rst = 1'b0;
    for (int s = 0; s < 3; s++) mdl_out[s] = '0;
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rst_mid[%0d]_pulses: got %0d bad cycles want 0", at_c, bad); end
    model_req(0, 1'b1, 1'b0, 9'h020, 32'h0, 1, ed, edc, ee, er, eo);
    run_req(0, 1'b1, 1'b0, 9'h020, 32'h0, 1, nd, dc, ne, ec, rl, of);
    n_cmp++; if (of !== prior) begin n_fail++; $display("FAIL rst_mid[%0d]_ram: got %h want %h", at_c, of, prior); end
  endtask

  task automatic test_back_to_back();
    int nd, dc, ne, ec, rl, ed, edc, ee, er;
    logic [31:0] of, eo;
    model_req(0, 1'b0, 1'b1, 9'h030, 32'hA5A5A5A5, 1, ed, edc, ee, er, eo);
    run_req(0, 1'b0, 1'b1, 9'h030, 32'hA5A5A5A5, 1, nd, dc, ne, ec, rl, of);
    n_cmp++; if (nd !== 1 || dc !== 4 || rl !== 5) begin n_fail++; $display("FAIL b2b_wr: got cnt=%0d cyc=%0d rel=%0d want 1/4/5", nd, dc, rl); end
    model_req(0, 1'b1, 1'b0, 9'h030, 32'h0, 1, ed, edc, ee, er, eo);
    run_req(0, 1'b1, 1'b0, 9'h030, 32'h0, 1, nd, dc, ne, ec, rl, of);
    n_cmp++; if (nd !== 1 || dc !== 4) begin n_fail++; $display("FAIL b2b_rd: got cnt=%0d cyc=%0d want 1/4", nd, dc); end
    n_cmp++; if (of !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_data: got %h want a5a5a5a5", of); end
  endtask

  task automatic test_random();
    int sel, hold, r, nd, dc, ne, ec, rl, ed, edc, ee, er;
    logic rd, wr;
    logic [8:0] a;
    logic [31:0] d, of, eo;
    for (int i = 0; i < 60; i++) begin
      sel  = $urandom_range(0, 2);
      hold = $urandom_range(1, 6);
      r    = $urandom_range(0, 7);
      d    = $urandom;
      a    = 9'($urandom_range(0, 511));
      rd   = (r <= 3);
      wr   = (r == 0) || (r >= 4);
      if (rd && !wr) begin
        for (int t = 0; t < 8 && !mdl_vld[sel][a]; t++) a = 9'($urandom_range(0, dp(sel) - 1));
        if (!mdl_vld[sel][a]) begin rd = 1'b0; wr = 1'b1; end
      end
      model_req(sel, rd, wr, a, d, hold, ed, edc, ee, er, eo);
      run_req(sel, rd, wr, a, d, hold, nd, dc, ne, ec, rl, of);
      n_cmp++; if (nd !== ed) begin n_fail++; $display("FAIL rnd[%0d] done_cnt: got %0d want %0d", i, nd, ed); end
      n_cmp++; if (ne !== ee) begin n_fail++; $display("FAIL rnd[%0d] err_cnt: got %0d want %0d", i, ne, ee); end
      if (ed == 1) begin
        n_cmp++; if (dc !== edc) begin n_fail++; $display("FAIL rnd[%0d] done_cyc: got %0d want %0d", i, dc, edc); end
      end
      n_cmp++; if (rl !== er) begin n_fail++; $display("FAIL rnd[%0d] release: got %0d want %0d", i, rl, er); end
      n_cmp++; if (of !== eo) begin n_fail++; $display("FAIL rnd[%0d] mem_out: got %h want %h", i, of, eo); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 9'h0, 32'h0);
    test_reset();
    test_write_w2();
    test_read_w0();
    test_held_read();
    test_illegal();
    test_reset_mid(1, 32'h11111111, 32'h12345678);
    test_reset_mid(3, 32'h22222222, 32'h12345678);
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
